// File: rtl/logs_pkg.sv
// Shared types and derived constants for the bit-serial logistic map iterator.
package logs_pkg;

  typedef enum logic [1:0] {
    LOAD,
    MUL1,
    MUL2,
    DONE
  } state_t;

  localparam int FRAC_DEF = 8;

  function automatic int mul1_cyc(input int f);
    return f + 1;
  endfunction

  function automatic int mul2_cyc(input int f);
    return f + 2;
  endfunction

  function automatic int period(input int f);
    return 2 * f + 5;
  endfunction

  function automatic int acc_w(input int f);
    return 2 * f + 2;
  endfunction

  localparam logic [FRAC_DEF-1:0] X_RESET =
    FRAC_DEF'(1) << (FRAC_DEF - 1);
  localparam int PERIOD   = period(FRAC_DEF);
  localparam int MUL1_CYC = mul1_cyc(FRAC_DEF);
  localparam int MUL2_CYC = mul2_cyc(FRAC_DEF);
  localparam int ACC_W    = acc_w(FRAC_DEF);

endpackage

// File: rtl/logs_shift_mul.sv
// Serial shift-add unsigned multiplier, one multiplier bit per cycle, LSB first.
module logs_shift_mul #(
  parameter int AW = 8,
  parameter int BW = 10,
  parameter int OW = 8,
  parameter int SH = 8,
  parameter int CW = $clog2(BW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic          start,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [CW-1:0] bits,
  output logic [OW-1:0] product,
  output logic [OW-1:0] sum,
  output logic          done
);

  localparam int PW = AW + BW;

  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [BW-1:0] mplier;
  logic [CW-1:0] cnt;

  logic [PW-1:0] cur_a;
  logic [PW-1:0] cur_acc;
  logic [PW-1:0] sum_full;
  logic [BW-1:0] cur_b;
  logic [CW-1:0] cur_cnt;

  // start performs the first step directly from the operand ports
  always_comb begin
    cur_a    = start ? PW'(a) : mcand;
    cur_b    = start ? b : mplier;
    cur_acc  = start ? '0 : acc;
    cur_cnt  = start ? '0 : cnt;
    sum_full = cur_acc + (cur_b[0] ? cur_a : '0);
    done     = en && (cur_cnt == bits - CW'(1));
  end

  assign product = acc[SH +: OW];
  assign sum     = sum_full[SH +: OW];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (en) begin
      acc    <= sum_full;
      mcand  <= cur_a << 1;
      mplier <= cur_b >> 1;
      cnt    <= cur_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/logs_serial_map.sv
// Bit-serial logistic map x' = r*x*(1-x) on one shared shift-add multiplier.
// Optional LOGS_ZERO_RESEED_EN: a zero result is replaced by 0.5.
module logs_serial_map
  import logs_pkg::*;
#(
  parameter int FRAC = FRAC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FRAC+1:0] r,
  output logic [FRAC-1:0] x,
  output logic            next_ready
);

  localparam int AW = FRAC;
  localparam int BW = FRAC + 2;
  localparam int CW = $clog2(BW + 1);
  localparam logic [FRAC-1:0] X_RST = FRAC'(1) << (FRAC - 1);

  state_t state;
  state_t state_n;

  logic [FRAC+1:0] r_lat;
  logic [FRAC:0]   y;
  logic            start;
  logic [AW-1:0]   op_a;
  logic [BW-1:0]   op_b;
  logic [CW-1:0]   bits;
  logic [FRAC-1:0] product;
  logic [FRAC-1:0] x_next;
  logic [FRAC-1:0] x_wr;
  logic            done;
  logic            busy;

  assign busy = (state == MUL1) || (state == MUL2);

  logs_shift_mul #(
    .AW(AW),
    .BW(BW),
    .OW(FRAC),
    .SH(FRAC),
    .CW(CW)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == LOAD),
    .en     (busy),
    .start  (start),
    .a      (op_a),
    .b      (op_b),
    .bits   (bits),
    .product(product),
    .sum    (x_next),
    .done   (done)
  );

  // MUL2 reads p = floor(x*y/2^FRAC) straight from the finished MUL1 product
  always_comb begin
    state_n = state;
    op_a    = x;
    op_b    = BW'(y);
    bits    = CW'(FRAC + 1);
    unique case (state)
      LOAD: state_n = MUL1;
      MUL1: if (done) state_n = MUL2;
      MUL2: begin
        op_a = product;
        op_b = r_lat;
        bits = CW'(FRAC + 2);
        if (done) state_n = DONE;
      end
      DONE: state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

`ifdef LOGS_ZERO_RESEED_EN
  assign x_wr = (x_next == '0) ? X_RST : x_next;
`else
  assign x_wr = x_next;
`endif

  assign next_ready = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      x     <= X_RST;
      r_lat <= '0;
      y     <= '0;
      start <= 1'b0;
    end else begin
      state <= state_n;
      start <= (state == LOAD) || ((state == MUL1) && done);
      if (state == LOAD) begin
        r_lat <= r;
        y     <= {1'b1, {FRAC{1'b0}}} - {1'b0, x};
      end
      if ((state == MUL2) && done) x <= x_wr;
    end
  end

endmodule
